// File: rtl/cci_mpf_shim_vtp_miss_sched_if.sv
// Miss-scheduler bus: TLB miss ports, page-walker request/response and TLB fill port.
// The slave modport is the scheduler; the master modport is the TLB/walker environment.
interface cci_mpf_shim_vtp_miss_sched_if #(
    parameter int VA_IDX_BITS = 36,
    parameter int PA_IDX_BITS = 26
);
    logic [1:0]                  miss_en;
    logic [1:0][VA_IDX_BITS-1:0] miss_va;
    logic                        miss_rdy;
    logic                        walk_req_en;
    logic [VA_IDX_BITS-1:0]      walk_req_va;
    logic                        walk_req_rdy;
    logic                        walk_rsp_en;
    logic [PA_IDX_BITS-1:0]      walk_rsp_pa;
    logic                        walk_rsp_big;
    logic                        walk_rsp_err;
    logic                        fill_en;
    logic [VA_IDX_BITS-1:0]      fill_va;
    logic [PA_IDX_BITS-1:0]      fill_pa;
    logic                        fill_big_page;
    logic                        fill_rdy;
    logic                        fault;
    logic [15:0]                 stat_misses;
    logic [15:0]                 stat_dups;

    modport slave (
        input  miss_en, miss_va, walk_req_rdy, walk_rsp_en, walk_rsp_pa, walk_rsp_big,
               walk_rsp_err, fill_rdy,
        output miss_rdy, walk_req_en, walk_req_va, fill_en, fill_va, fill_pa, fill_big_page,
               fault, stat_misses, stat_dups
    );

    modport master (
        output miss_en, miss_va, walk_req_rdy, walk_rsp_en, walk_rsp_pa, walk_rsp_big,
               walk_rsp_err, fill_rdy,
        input  miss_rdy, walk_req_en, walk_req_va, fill_en, fill_va, fill_pa, fill_big_page,
               fault, stat_misses, stat_dups
    );
endinterface

// File: rtl/cci_mpf_shim_vtp_miss_sched.sv
// VTP miss scheduler: merges TLB misses from two ports in a small table, walks one at a time
// and fills the TLB with the result (2MB results also retire every pending miss in that page).
module cci_mpf_shim_vtp_miss_sched #(
    parameter int N_MISS_ENTRIES = 4,
    parameter int VA_IDX_BITS    = 36,
    parameter int PA_IDX_BITS    = 26
) (
    input logic clk,
    input logic reset,
    cci_mpf_shim_vtp_miss_sched_if.slave bus
);
    localparam int N     = N_MISS_ENTRIES;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t                      state, stateNext;
    logic [N-1:0]                valid, walking;
    logic [N-1:0][VA_IDX_BITS-1:0] entVa;
    logic [IDX_W-1:0]            curIdx, selIdx;
    logic [VA_IDX_BITS-1:0]      curVa;
    logic [PA_IDX_BITS-1:0]      curPa;
    logic                        curBig, selHit;
    logic                        missRdy, faultQ, faultNext;
    logic [15:0]                 statMisses, statDups;
    logic [N-1:0]                freeMask, liveValid, alloc0, alloc1, validNext;
    logic                        tblHit0, tblHit1, hit0, hit1, new0, new1, got0, got1;
    logic [CNT_W-1:0]            freeCnt;
    logic [16:0]                 missSum, dupSum;

    // FSM next state, plus which entries retire this cycle.
    always_comb begin
        stateNext = state;
        selHit    = 1'b0;
        selIdx    = '0;
        freeMask  = '0;
        faultNext = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i] && !walking[i]) begin
                selHit = 1'b1;
                selIdx = IDX_W'(i);
            end
        end
        case (state)
            IDLE: if (selHit) stateNext = REQ;
            REQ:  if (bus.walk_req_rdy) stateNext = WAIT;
            WAIT: if (bus.walk_rsp_en) begin
                if (bus.walk_rsp_err) begin
                    freeMask[curIdx] = 1'b1;
                    faultNext        = 1'b1;
                    stateNext        = IDLE;
                end else begin
                    stateNext = FILL;
                end
            end
            FILL: if (bus.fill_rdy) begin
                freeMask[curIdx] = 1'b1;
                if (curBig) begin
                    for (int i = 0; i < N; i++) begin
                        if (valid[i] && !walking[i] &&
                            entVa[i][VA_IDX_BITS-1:9] == curVa[VA_IDX_BITS-1:9])
                            freeMask[i] = 1'b1;
                    end
                end
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Miss merge and allocation. Entries retiring this cycle neither match nor get reused.
    always_comb begin
        liveValid = valid & ~freeMask;
        tblHit0   = 1'b0;
        tblHit1   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (liveValid[i] && entVa[i] == bus.miss_va[0]) tblHit0 = 1'b1;
            if (liveValid[i] && entVa[i] == bus.miss_va[1]) tblHit1 = 1'b1;
        end
        hit0 = missRdy && bus.miss_en[0] && tblHit0;
        new0 = missRdy && bus.miss_en[0] && !tblHit0;
        hit1 = missRdy && bus.miss_en[1] && (tblHit1 || (new0 && bus.miss_va[1] == bus.miss_va[0]));
        new1 = missRdy && bus.miss_en[1] && !hit1;
        alloc0 = '0;
        alloc1 = '0;
        got0   = 1'b0;
        got1   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (new0 && !got0 && !valid[i]) begin
                alloc0[i] = 1'b1;
                got0      = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (new1 && !got1 && !valid[i] && !alloc0[i]) begin
                alloc1[i] = 1'b1;
                got1      = 1'b1;
            end
        end
        validNext = liveValid | alloc0 | alloc1;
        freeCnt   = '0;
        for (int i = 0; i < N; i++)
            if (!validNext[i]) freeCnt = freeCnt + CNT_W'(1);
        missSum = {1'b0, statMisses} + 17'(new0) + 17'(new1);
        dupSum  = {1'b0, statDups} + 17'(hit0) + 17'(hit1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            walking    <= '0;
            entVa      <= '0;
            curIdx     <= '0;
            curVa      <= '0;
            curPa      <= '0;
            curBig     <= 1'b0;
            missRdy    <= 1'b1;
            faultQ     <= 1'b0;
            statMisses <= '0;
            statDups   <= '0;
        end else begin
            valid   <= validNext;
            walking <= walking & ~freeMask;
            for (int i = 0; i < N; i++) begin
                if (alloc0[i]) entVa[i] <= bus.miss_va[0];
                if (alloc1[i]) entVa[i] <= bus.miss_va[1];
            end
            if (state == IDLE && selHit) begin
                walking[selIdx] <= 1'b1;
                curIdx          <= selIdx;
                curVa           <= entVa[selIdx];
            end
            if (state == WAIT && bus.walk_rsp_en && !bus.walk_rsp_err) begin
                curPa  <= bus.walk_rsp_pa;
                curBig <= bus.walk_rsp_big;
            end
            missRdy    <= (freeCnt >= CNT_W'(2));
            faultQ     <= faultNext;
            statMisses <= missSum[16] ? 16'hFFFF : missSum[15:0];
            statDups   <= dupSum[16]  ? 16'hFFFF : dupSum[15:0];
        end
    end

    assign bus.miss_rdy      = missRdy;
    assign bus.walk_req_en   = (state == REQ);
    assign bus.walk_req_va   = curVa;
    assign bus.fill_en       = (state == FILL);
    assign bus.fill_va       = curBig ? {curVa[VA_IDX_BITS-1:9], 9'b0} : curVa;
    assign bus.fill_pa       = curBig ? {curPa[PA_IDX_BITS-1:9], 9'b0} : curPa;
    assign bus.fill_big_page = (state == FILL) && curBig;
    assign bus.fault         = faultQ;
    assign bus.stat_misses   = statMisses;
    assign bus.stat_dups     = statDups;
endmodule
